// File: rtl/axi_pkg.sv
// Shared AXI burst definitions used by the slave-side address generators.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int unsigned BOUNDARY_4K = 4096;
  localparam int unsigned PAGE_LSB    = $clog2(BOUNDARY_4K);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  // WRAP bursts are only defined for power-of-two lengths 2..16.
  function automatic logic legal_wrap_len(input logic [31:0] len);
    return (len == 32'd2) || (len == 32'd4) || (len == 32'd8) || (len == 32'd16);
  endfunction

endpackage

// File: rtl/axi_next_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// The caller supplies an already-corrected command and the wrap lower bound.
module axi_next_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [1:0]        i_type,
  input  logic [ADDR_W-1:0] i_wrap_lo,
  output logic [ADDR_W-1:0] o_next
);

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_wrap_hi;

  assign w_bytes   = ADDR_W'(1) << i_size;
  // Step from the aligned address so an unaligned INCR start snaps onto the grid.
  assign w_incr    = (i_addr & ~(w_bytes - ADDR_W'(1))) + w_bytes;
  // Upper bound is exclusive; equality works even when it wraps modulo 2^ADDR_W.
  assign w_wrap_hi = i_wrap_lo + (ADDR_W'(i_len) << i_size);

  // Select the next address according to the burst type.
  always_comb begin
    o_next = w_incr;
    case (i_type)
      BURST_FIXED: o_next = i_addr;
      BURST_WRAP:  o_next = (w_incr == w_wrap_hi) ? i_wrap_lo : w_incr;
      default:     o_next = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Slave-side per-beat address generator: accepts one burst command, corrects
// illegal fields, then issues one address per beat over a valid/ready handshake.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 6,
  parameter int MAX_SIZE_LOG2 = 2
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_type,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              beat_last,
  output logic              busy,
  output logic              cmd_err
);

  burst_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_type;
  logic [ADDR_W-1:0] r_wrap_lo;
  logic              r_err;

  logic              w_accept;
  logic              w_advance;
  logic              w_is_last;
  logic [ADDR_W-1:0] w_next;

  // Corrected command fields, valid in the accept cycle.
  logic [2:0]        w_size_c;
  logic [LEN_W-1:0]  w_len_c;
  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_aligned;
  logic [ADDR_W-1:0] w_wrap_sz;
  logic [ADDR_W-1:0] w_wrap_lo;
  logic [ADDR_W-1:0] w_incr_last;
  logic              w_wrap_ok;
  logic              w_cross_4k;
  logic [1:0]        w_type_c;
  logic [ADDR_W-1:0] w_start_c;
  logic              w_err;

  assign w_size_c    = (cmd_size > 3'(MAX_SIZE_LOG2)) ? 3'(MAX_SIZE_LOG2) : cmd_size;
  assign w_len_c     = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
  assign w_bytes     = ADDR_W'(1) << w_size_c;
  assign w_aligned   = cmd_addr & ~(w_bytes - ADDR_W'(1));
  assign w_wrap_ok   = legal_wrap_len(32'(w_len_c));
  assign w_wrap_sz   = ADDR_W'(w_len_c) << w_size_c;
  assign w_wrap_lo   = cmd_addr & ~(w_wrap_sz - ADDR_W'(1));
  assign w_incr_last = w_aligned + (ADDR_W'(w_len_c - LEN_W'(1)) << w_size_c);
  assign w_cross_4k  = cmd_addr[ADDR_W-1:PAGE_LSB] != w_incr_last[ADDR_W-1:PAGE_LSB];

  // Resolve burst type, start address and error flag for the incoming command.
  always_comb begin
    w_type_c  = cmd_type;
    w_start_c = cmd_addr;
    w_err     = (cmd_size > 3'(MAX_SIZE_LOG2));
    case (cmd_type)
      BURST_FIXED: ;
      BURST_WRAP: begin
        if (w_wrap_ok) begin
          w_start_c = w_aligned;
          if (cmd_addr != w_aligned) w_err = 1'b1;
        end else begin
          w_type_c = BURST_INCR;
          w_err    = 1'b1;
        end
      end
      BURST_INCR: ;
      default: begin
        w_type_c = BURST_INCR;
        w_err    = 1'b1;
      end
    endcase
    if ((w_type_c == BURST_INCR) && w_cross_4k) w_err = 1'b1;
  end

  axi_next_addr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_next (
    .i_addr    (r_addr),
    .i_size    (r_size),
    .i_len     (r_len),
    .i_type    (r_type),
    .i_wrap_lo (r_wrap_lo),
    .o_next    (w_next)
  );

  assign w_is_last = (r_idx == (r_len - LEN_W'(1)));

  // State register.
  always_ff @(posedge aclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    cmd_ready   = 1'b0;
    beat_valid  = 1'b0;
    busy        = 1'b0;
    beat_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid && !reset) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        beat_valid = 1'b1;
        busy       = 1'b1;
        beat_last  = w_is_last;
        if (beat_ready) begin
          w_advance = 1'b1;
          if (w_is_last) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, beat counter and address register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_addr    <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_type    <= '0;
      r_wrap_lo <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept && w_err;
      if (w_accept) begin
        r_addr    <= w_start_c;
        r_idx     <= '0;
        r_len     <= w_len_c;
        r_size    <= w_size_c;
        r_type    <= w_type_c;
        r_wrap_lo <= w_wrap_lo;
      end else if (w_advance && !w_is_last) begin
        r_addr <= w_next;
        r_idx  <= r_idx + LEN_W'(1);
      end
    end
  end

  assign beat_addr = r_addr;
  assign beat_idx  = r_idx;
  assign cmd_err   = r_err;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed and randomized bursts
// compared against an arithmetic reference model of the burst address rules.
module tb_axi_burst_addr_gen;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [5:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_type = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic [31:0] beat_addr;
  logic [5:0]  beat_idx;
  logic        beat_last;
  logic        busy;
  logic        cmd_err;

  always #5 aclk = ~aclk;

  axi_burst_addr_gen #(.ADDR_W(32), .LEN_W(6), .MAX_SIZE_LOG2(2)) dut (
    .aclk(aclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_type(cmd_type),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_idx(beat_idx), .beat_last(beat_last), .busy(busy), .cmd_err(cmd_err)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_addr[64];
  int          exp_n;
  logic        exp_err;

  logic [31:0] obs_addr[64];
  logic [5:0]  obs_idx[64];
  logic        obs_last[64];
  int          obs_n;
  logic [31:0] cyc_addr[256];
  logic [5:0]  cyc_idx[256];
  logic        cyc_valid[256];
  logic        cyc_rdy[256];
  logic        cyc_err[256];
  int          ncyc;
  bit          tmo;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  l;
    logic [2:0]  s;
    logic [1:0]  t;
  } cmd_t;

  // Reference: expected beat addresses and error flag straight from the burst rules.
  task automatic model(input logic [31:0] a, input logic [5:0] l, input logic [2:0] s,
                       input logic [1:0] t);
    int sz, len;
    logic [31:0] b, al, w, lo, lastb;
    logic [1:0] et;
    sz  = (s > 3'd2) ? 2 : int'(s);
    len = (l == 6'd0) ? 1 : int'(l);
    b   = 32'd1 << sz;
    al  = a - (a % b);
    et  = t;
    exp_err = (s > 3'd2);
    if (t == 2'b11) begin et = BURST_INCR; exp_err = 1'b1; end
    if (et == BURST_WRAP && !(len == 2 || len == 4 || len == 8 || len == 16)) begin
      et = BURST_INCR; exp_err = 1'b1;
    end
    if (et == BURST_WRAP && a != al) exp_err = 1'b1;
    lastb = al + 32'(len - 1) * b;
    if (et == BURST_INCR && (a / 32'd4096) != (lastb / 32'd4096)) exp_err = 1'b1;
    w  = 32'(len) * b;
    lo = (a / w) * w;
    exp_n = len;
    for (int n = 0; n < len; n++) begin
      if (et == BURST_FIXED)     exp_addr[n] = a;
      else if (et == BURST_WRAP) exp_addr[n] = lo + ((al - lo + 32'(n) * b) % w);
      else                       exp_addr[n] = (n == 0) ? a : al + 32'(n) * b;
    end
  endtask

  // Drive one command and record every cycle of the resulting burst.
  task automatic do_burst(input logic [31:0] a, input logic [5:0] l, input logic [2:0] s,
                          input logic [1:0] t, input int pct, input logic [31:0] stall);
    int  c;
    bit  done;
    bit  st;
    tmo = 1'b0; obs_n = 0; ncyc = 0; done = 1'b0; c = 0;
    while (!cmd_ready && c < 50) begin @(posedge aclk); #1; c++; end
    if (!cmd_ready) tmo = 1'b1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_type = t;
    @(posedge aclk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 6'($urandom); cmd_size = 3'($urandom);
    cmd_type = 2'($urandom);
    while (!done && ncyc < 256) begin
      st = (ncyc < 32) ? stall[ncyc[4:0]] : 1'b0;
      beat_ready = !st && ($urandom_range(99) < pct);
      @(negedge aclk);
      cyc_addr[ncyc] = beat_addr; cyc_idx[ncyc] = beat_idx; cyc_valid[ncyc] = beat_valid;
      cyc_rdy[ncyc] = beat_ready; cyc_err[ncyc] = cmd_err;
      if (beat_valid && beat_ready && obs_n < 64) begin
        obs_addr[obs_n] = beat_addr; obs_idx[obs_n] = beat_idx; obs_last[obs_n] = beat_last;
        obs_n++;
        if (beat_last || obs_n == 64) done = 1'b1;
      end
      ncyc++;
      @(posedge aclk); #1;
    end
    beat_ready = 1'b0;
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b0) begin $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); fails++; end
    checks++;
    if ({beat_valid, busy, cmd_err, beat_last} !== 4'b0000) begin
      $display("FAIL reset_flags: got v%b b%b e%b l%b want all 0", beat_valid, busy, cmd_err, beat_last);
      fails++;
    end
    checks++;
    if (beat_addr !== 32'h0 || beat_idx !== 6'h0) begin
      $display("FAIL reset_addr_idx: got %h/%0d want 0/0", beat_addr, beat_idx); fails++;
    end
    @(posedge aclk); #1 reset = 1'b0;
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b1) begin $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); fails++; end
  endtask

  // Directed bursts: plain INCR/WRAP/FIXED plus every correction case.
  task automatic test_directed();
    cmd_t tab[11];
    int ec;
    tab[0]  = '{32'h65,   6'd4, 3'd2, BURST_INCR};
    tab[1]  = '{32'h68,   6'd4, 3'd2, BURST_WRAP};
    tab[2]  = '{32'h40,   6'd3, 3'd2, BURST_FIXED};
    tab[3]  = '{32'h80,   6'd3, 3'd2, BURST_WRAP};
    tab[4]  = '{32'hFF8,  6'd4, 3'd2, BURST_INCR};
    tab[5]  = '{32'h200,  6'd2, 3'd5, BURST_INCR};
    tab[6]  = '{32'h300,  6'd3, 3'd2, 2'b11};
    tab[7]  = '{32'h6A,   6'd4, 3'd2, BURST_WRAP};
    tab[8]  = '{32'h10,   6'd0, 3'd1, BURST_INCR};
    tab[9]  = '{32'h3C,   6'd8, 3'd1, BURST_WRAP};
    tab[10] = '{32'h1003, 6'd3, 3'd0, BURST_FIXED};
    for (int k = 0; k < 11; k++) begin
      model(tab[k].a, tab[k].l, tab[k].s, tab[k].t);
      do_burst(tab[k].a, tab[k].l, tab[k].s, tab[k].t, 100, 32'h0);
      checks++;
      if (tmo || obs_n != exp_n) begin
        $display("FAIL dir%0d_count: got %0d beats (timeout %0d) want %0d", k, obs_n, tmo, exp_n); fails++;
      end
      checks++;
      if (cyc_valid[0] !== 1'b1) begin $display("FAIL dir%0d_latency: beat_valid got %b want 1", k, cyc_valid[0]); fails++; end
      for (int i = 0; i < exp_n && i < obs_n; i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i]) begin
          $display("FAIL dir%0d_addr[%0d]: got %h want %h", k, i, obs_addr[i], exp_addr[i]); fails++;
        end
        checks++;
        if (obs_idx[i] !== 6'(i) || obs_last[i] !== (i == exp_n - 1)) begin
          $display("FAIL dir%0d_idx_last[%0d]: got %0d/%b want %0d/%b", k, i, obs_idx[i], obs_last[i], i, (i == exp_n - 1));
          fails++;
        end
      end
      ec = 0;
      for (int c = 0; c < ncyc; c++) ec += int'(cyc_err[c]);
      checks++;
      if (cyc_err[0] !== exp_err || ec != int'(exp_err)) begin
        $display("FAIL dir%0d_cmd_err: got first %b pulses %0d want %b", k, cyc_err[0], ec, exp_err); fails++;
      end
      @(negedge aclk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        $display("FAIL dir%0d_idle_after: got ready %b busy %b want 1 0", k, cmd_ready, busy); fails++;
      end
    end
  endtask

  // Consumer stalls two cycles on beat 1; address and index must hold.
  task automatic test_backpressure();
    model(32'h100, 6'd4, 3'd2, BURST_INCR);
    do_burst(32'h100, 6'd4, 3'd2, BURST_INCR, 100, 32'b110);
    checks++;
    if (tmo || ncyc != 6 || obs_n != 4) begin
      $display("FAIL bp_cycles: got %0d cycles %0d beats want 6 4", ncyc, obs_n); fails++;
    end
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (cyc_valid[c] !== 1'b1 || cyc_addr[c] !== 32'h104 || cyc_idx[c] !== 6'd1) begin
        $display("FAIL bp_hold[%0d]: got v%b %h/%0d want v1 00000104/1", c, cyc_valid[c], cyc_addr[c], cyc_idx[c]);
        fails++;
      end
    end
    for (int i = 0; i < 4 && i < obs_n; i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i]) begin
        $display("FAIL bp_addr[%0d]: got %h want %h", i, obs_addr[i], exp_addr[i]); fails++;
      end
    end
  endtask

  // Reset after the beat-1 handshake of an 8-beat burst.
  task automatic test_reset_mid();
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_len = 6'd8; cmd_size = 3'd2; cmd_type = BURST_INCR;
    beat_ready = 1'b1;
    @(posedge aclk); #1 cmd_valid = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (beat_idx !== 6'd1 || beat_addr !== 32'h204) begin
      $display("FAIL mid_beat1: got %h/%0d want 00000204/1", beat_addr, beat_idx); fails++;
    end
    @(posedge aclk); #1;
    reset = 1'b1; beat_ready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({beat_valid, busy, cmd_ready, cmd_err} !== 4'b0000 || beat_idx !== 6'd0 || beat_addr !== 32'h0) begin
      $display("FAIL mid_reset_state: got v%b b%b r%b %h/%0d want all 0", beat_valid, busy, cmd_ready, beat_addr, beat_idx);
      fails++;
    end
    @(posedge aclk); #1 reset = 1'b0;
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b1) begin $display("FAIL mid_release_ready: got %b want 1", cmd_ready); fails++; end
    model(32'h400, 6'd2, 3'd2, BURST_INCR);
    do_burst(32'h400, 6'd2, 3'd2, BURST_INCR, 100, 32'h0);
    checks++;
    if (tmo || obs_n != 2 || obs_idx[0] !== 6'd0 || obs_addr[0] !== exp_addr[0] || obs_addr[1] !== exp_addr[1]) begin
      $display("FAIL mid_restart: got n%0d idx0 %0d %h %h want n2 idx0 0 %h %h",
               obs_n, obs_idx[0], obs_addr[0], obs_addr[1], exp_addr[0], exp_addr[1]);
      fails++;
    end
  endtask

  // Random commands with random consumer backpressure.
  task automatic test_random();
    logic [31:0] a;
    logic [5:0]  l;
    logic [2:0]  s;
    logic [1:0]  t;
    int ec;
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      if ($urandom_range(1) == 1) a[11:4] = 8'hFF;
      l = 6'($urandom_range(0, 16));
      if ($urandom_range(2) == 0) l = 6'(2 << $urandom_range(0, 3));
      s = 3'($urandom_range(0, 4));
      t = 2'($urandom_range(0, 3));
      model(a, l, s, t);
      do_burst(a, l, s, t, $urandom_range(40, 100), 32'h0);
      checks++;
      if (tmo || obs_n != exp_n) begin
        $display("FAIL rnd%0d_count: got %0d beats (timeout %0d) want %0d", k, obs_n, tmo, exp_n); fails++;
      end
      for (int i = 0; i < exp_n && i < obs_n; i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_idx[i] !== 6'(i) || obs_last[i] !== (i == exp_n - 1)) begin
          $display("FAIL rnd%0d_beat[%0d]: got %h/%0d/%b want %h/%0d/%b", k, i, obs_addr[i], obs_idx[i],
                   obs_last[i], exp_addr[i], i, (i == exp_n - 1));
          fails++;
        end
      end
      ec = 0;
      for (int c = 0; c < ncyc; c++) begin
        ec += int'(cyc_err[c]);
        checks++;
        if (cyc_valid[c] !== 1'b1) begin $display("FAIL rnd%0d_bubble[%0d]: beat_valid got %b want 1", k, c, cyc_valid[c]); fails++; end
        if (c + 1 < ncyc && !cyc_rdy[c]) begin
          checks++;
          if (cyc_addr[c+1] !== cyc_addr[c] || cyc_idx[c+1] !== cyc_idx[c]) begin
            $display("FAIL rnd%0d_hold[%0d]: got %h/%0d want %h/%0d", k, c, cyc_addr[c+1], cyc_idx[c+1], cyc_addr[c], cyc_idx[c]);
            fails++;
          end
        end
      end
      checks++;
      if (cyc_err[0] !== exp_err || ec != int'(exp_err)) begin
        $display("FAIL rnd%0d_cmd_err: got first %b pulses %0d want %b", k, cyc_err[0], ec, exp_err); fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
Per-beat address generator for the slave side of the AXI write and read data channels.
- Accepts one burst command: start address, beat count, beat size, burst type (FIXED/INCR/WRAP).
- Emits one address per beat over a valid/ready handshake, with beat index and last flag.
- Sits between the AW/AR address handshake and the slave memory port; one instance each for write and read.

Parameters:
ADDR_W, 32, address width in bits
LEN_W, 6, width of beat-count field (beats = cmd_len, 1..2^LEN_W-1)
MAX_SIZE_LOG2, 2, largest legal beat size as log2(bytes); 2 = 4-byte data bus

Ports:
aclk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  block can accept a command
cmd_addr  in  ADDR_W  start byte address
cmd_len  in  LEN_W  number of beats (0 treated as 1)
cmd_size  in  3  log2(bytes per beat)
cmd_type  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat_addr valid
beat_ready  in  1  consumer takes beat
beat_addr  out  ADDR_W  byte address of current beat
beat_idx  out  LEN_W  zero-based beat number
beat_last  out  1  current beat is final beat
busy  out  1  burst in progress
cmd_err  out  1  one-cycle pulse: command was corrected

Behaviour:
- Clock and reset: one clock, aclk. Reset is synchronous, active-high, on port reset.
- Reset values: cmd_ready=0 while reset is high, then 1 on the first cycle after release. beat_valid, beat_addr, beat_idx, beat_last, busy and cmd_err are all 0.
- States: IDLE and BURST.
- IDLE:
  - cmd_ready=1 and beat_valid=0.
  - On cmd_valid&cmd_ready, latch the command and go to BURST.
  - beat_valid=1 with beat 0 on the next cycle (latency 1).
- BURST:
  - cmd_ready=0 and busy=1.
  - Advance on beat_valid&beat_ready: beat_idx+1 and the next address is registered.
  - beat_valid stays 1 with no bubble between beats.
  - beat_addr, beat_idx and beat_last are held stable while beat_ready=0.
  - beat_last=1 when beat_idx==len-1.
  - The handshake on the last beat moves the block to IDLE, and cmd_ready=1 on the next cycle. There is no same-cycle command acceptance.
- Address rules (bytes B = 1<<size, aligned A = cmd_addr with low size bits cleared):
  - FIXED: every beat = cmd_addr.
  - INCR: beat 0 = cmd_addr; beat n = A + n*B.
  - WRAP:
    - Wrap window W = len*B; lower bound = cmd_addr rounded down to a multiple of W.
    - beat 0 = A. Each next address = previous + B; on reaching lower bound + W it goes to lower bound.
  - All arithmetic is modulo 2^ADDR_W; W is computed in ADDR_W bits.
- Correction cases (cmd_err pulses in the first beat_valid cycle; corrections are applied before beat 0):
  - cmd_size > MAX_SIZE_LOG2: clamp to MAX_SIZE_LOG2.
  - cmd_type==11: treat as INCR.
  - WRAP with len not in {2,4,8,16}: treat as INCR.
  - WRAP with unaligned cmd_addr: use A as the start address.
  - INCR burst crossing a 4 KB boundary: flag the error, continue the addresses unchanged.
  - cmd_len=0: treat as 1 beat. This case does not raise cmd_err.
- Reset mid-burst: the state is abandoned at the next edge and all outputs return to reset values. Nothing from the partial burst is retained.

Decomposition:
- Shared package axi_pkg:
  - Burst-type constants BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - Constant BOUNDARY_4K=4096.
  - Function legal_wrap_len(len).
- One natural sub-module, axi_next_addr: combinational next-address computation from (addr, size, len, type, wrap bound). It can be reused by master-side generators.
- The FSM, counters and handshake stay in axi_burst_addr_gen.

Test Plan:
1. INCR addr 0x65, size 2, len 4: beats 0x65, 0x68, 0x6C, 0x70; beat_last only on idx 3; cmd_ready=1 the cycle after the last handshake.
2. WRAP addr 0x68, size 2, len 4: bound 0x60; beats 0x68, 0x6C, 0x60, 0x64; cmd_err=0.
3. FIXED addr 0x40, size 2, len 3: three beats all 0x40; beat_idx 0, 1, 2.
4. INCR addr 0x100, len 4, beat_ready low 2 cycles at idx 1: beat_addr held at 0x104 and idx held at 1 for those cycles; burst completes with 0x108, 0x10C.
5. WRAP len 3, addr 0x80, size 2: cmd_err pulses 1 cycle with beat 0; beats 0x80, 0x84, 0x88 (INCR). INCR addr 0xFF8, len 4: cmd_err pulses; beats 0xFF8, 0xFFC, 0x1000, 0x1004.
6. Reset asserted after beat-1 handshake of an INCR len-8 burst: next cycle beat_valid=0 and busy=0; after release cmd_ready=1, and a new command restarts at idx 0.
